// File: rtl/ram_tdp_be.sv
// True dual-port byte-enabled RAM with selectable same-port read-during-write
// behaviour, optional output register, per-port read-valid and collision flag.
module ram_tdp_be #(
    parameter int unsigned BYTE_BIT_WIDTH = 8,
    parameter int unsigned WORD_BYTES     = 4,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned USE_OUTPUT_REG = 0,
    localparam int unsigned W             = BYTE_BIT_WIDTH * WORD_BYTES,
    localparam int unsigned AW            = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_async_rst,
    input  logic                  i_a_en,
    input  logic                  i_a_we,
    input  logic [AW-1:0]         i_a_addr,
    input  logic [W-1:0]          i_a_data,
    input  logic [WORD_BYTES-1:0] i_a_byte_en,
    output logic [W-1:0]          o_a_data,
    output logic                  o_a_valid,
    input  logic                  i_b_en,
    input  logic                  i_b_we,
    input  logic [AW-1:0]         i_b_addr,
    input  logic [W-1:0]          i_b_data,
    input  logic [WORD_BYTES-1:0] i_b_byte_en,
    output logic [W-1:0]          o_b_data,
    output logic                  o_b_valid,
    output logic                  o_collision
);

    if (BYTE_BIT_WIDTH < 1 || WORD_BYTES < 1) begin : g_bad_width
        $error("ram_tdp_be: BYTE_BIT_WIDTH and WORD_BYTES must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_tdp_be: DEPTH must be a power of 2 and >= 2");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $error("ram_tdp_be: RDW_MODE must be 0, 1 or 2");
    end
    if (USE_OUTPUT_REG > 1) begin : g_bad_oreg
        $error("ram_tdp_be: USE_OUTPUT_REG must be 0 or 1");
    end

    logic [W-1:0]          mem [DEPTH];

    logic [1:0]            en;
    logic [1:0]            wr;
    logic [AW-1:0]         addr   [2];
    logic [W-1:0]          wdata  [2];
    logic [WORD_BYTES-1:0] be     [2];
    logic [W-1:0]          rd_old [2];

    logic [W-1:0]          s1_d     [2];
    logic [W-1:0]          s1_d_nxt [2];
    logic [1:0]            s1_v;
    logic [1:0]            s1_v_nxt;
    logic                  coll_c;

    function automatic logic [W-1:0] merge_word(input logic [W-1:0]          old_w,
                                                input logic [W-1:0]          new_w,
                                                input logic [WORD_BYTES-1:0] lanes);
        merge_word = old_w;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (lanes[k]) begin
                merge_word[k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH] = new_w[k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH];
            end
        end
    endfunction

    // Index 0 is port a, index 1 is port b.
    assign en     = {i_b_en, i_a_en};
    assign wr     = {i_b_en & i_b_we & ~i_async_rst, i_a_en & i_a_we & ~i_async_rst};
    assign addr[0]  = i_a_addr;
    assign addr[1]  = i_b_addr;
    assign wdata[0] = i_a_data;
    assign wdata[1] = i_b_data;
    assign be[0]    = i_a_byte_en;
    assign be[1]    = i_b_byte_en;
    assign rd_old[0] = mem[i_a_addr];
    assign rd_old[1] = mem[i_b_addr];

    // Storage: not reset; port a is applied last so it wins shared lanes.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (wr[1] && be[1][k]) begin
                mem[addr[1]][k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH] <= wdata[1][k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH];
            end
            if (wr[0] && be[0][k]) begin
                mem[addr[0]][k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH] <= wdata[0][k*BYTE_BIT_WIDTH +: BYTE_BIT_WIDTH];
            end
        end
    end

    // Stage-1 next value per port; cross-port reads naturally see pre-write data.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            s1_d_nxt[p] = s1_d[p];
            s1_v_nxt[p] = 1'b0;
            if (en[p]) begin
                if (!wr[p]) begin
                    s1_d_nxt[p] = rd_old[p];
                    s1_v_nxt[p] = 1'b1;
                end else if (RDW_MODE == 0) begin
                    s1_d_nxt[p] = merge_word(rd_old[p], wdata[p], be[p]);
                    s1_v_nxt[p] = 1'b1;
                end else if (RDW_MODE == 1) begin
                    s1_d_nxt[p] = rd_old[p];
                    s1_v_nxt[p] = 1'b1;
                end
            end
        end
    end

    assign coll_c = wr[0] & wr[1] & (addr[0] == addr[1]) & (|(be[0] & be[1]));

    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            s1_d[0]     <= '0;
            s1_d[1]     <= '0;
            s1_v        <= '0;
            o_collision <= 1'b0;
        end else begin
            s1_d[0]     <= s1_d_nxt[0];
            s1_d[1]     <= s1_d_nxt[1];
            s1_v        <= s1_v_nxt;
            o_collision <= coll_c;
        end
    end

    if (USE_OUTPUT_REG == 1) begin : g_oreg
        logic [W-1:0] s2_d [2];
        logic [1:0]   s2_v;

        always_ff @(posedge i_clk or posedge i_async_rst) begin
            if (i_async_rst) begin
                s2_d[0] <= '0;
                s2_d[1] <= '0;
                s2_v    <= '0;
            end else begin
                s2_d[0] <= s1_d[0];
                s2_d[1] <= s1_d[1];
                s2_v    <= s1_v;
            end
        end

        assign o_a_data  = s2_d[0];
        assign o_b_data  = s2_d[1];
        assign o_a_valid = s2_v[0];
        assign o_b_valid = s2_v[1];
    end else begin : g_noreg
        assign o_a_data  = s1_d[0];
        assign o_b_data  = s1_d[1];
        assign o_a_valid = s1_v[0];
        assign o_b_valid = s1_v[1];
    end

endmodule
